// File: rtl/cmd_dispatch.sv
// Command dispatcher: takes 16-bit commands from the UART wrapper, launches
// calibrate/move operations, waits for completion or timeout, and returns a
// one-byte status response through the UART transmit handshake.
module cmd_dispatch #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  ACK     = 8'hA5,
  parameter logic [7:0]  NAK     = 8'h5A,
  parameter logic [7:0]  TMO     = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_i,
  input  logic        cmd_rdy_i,
  output logic        clr_cmd_rdy_o,
  output logic        strt_cal_o,
  input  logic        cal_done_i,
  output logic        strt_mv_o,
  output logic [7:0]  mv_heading_o,
  output logic [3:0]  mv_squares_o,
  input  logic        mv_done_i,
  output logic [7:0]  resp_o,
  output logic        trmt_o,
  input  logic        tx_done_i,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCalWait, StMvWait, StRespWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tx_done_q;
  logic            clr_q, clr_d;
  logic            strt_cal_q, strt_cal_d;
  logic            strt_mv_q, strt_mv_d;
  logic            trmt_q, trmt_d;
  logic            busy_q, busy_d;
  logic [7:0]      resp_q, resp_d;
  logic [7:0]      hd_q, hd_d;
  logic [3:0]      sq_q, sq_d;

  logic is_cal, is_mv, mv_zero, tx_rise, expired, op_done;

  assign is_cal  = (cmd_i[15:12] == 4'h2);
  assign is_mv   = (cmd_i[15:12] == 4'h4);
  assign mv_zero = (cmd_i[3:0] == 4'h0);
  // Only a fresh edge releases RESP_WAIT; a level left high from a prior
  // transmission must not.
  assign tx_rise = tx_done_i & ~tx_done_q;
  assign expired = (cnt_q == CntW'(TIMEOUT));
  // Only the done input matching the current wait state counts.
  assign op_done = (state_q == StCalWait) ? cal_done_i : mv_done_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_rdy_i) begin
          if (is_cal)                state_d = StCalWait;
          else if (is_mv && !mv_zero) state_d = StMvWait;
          else                        state_d = StRespWait;
        end
      end
      StCalWait, StMvWait: begin
        if (op_done || expired) state_d = StRespWait;
      end
      StRespWait: begin
        if (tx_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs and the timeout counter.
  always_comb begin
    clr_d      = 1'b0;
    strt_cal_d = 1'b0;
    strt_mv_d  = 1'b0;
    trmt_d     = 1'b0;
    resp_d     = resp_q;
    hd_d       = hd_q;
    sq_d       = sq_q;
    cnt_d      = '0;
    busy_d     = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (cmd_rdy_i) begin
          clr_d = 1'b1;
          if (is_cal) begin
            strt_cal_d = 1'b1;
          end else if (is_mv && !mv_zero) begin
            strt_mv_d = 1'b1;
            hd_d      = cmd_i[11:4];
            sq_d      = cmd_i[3:0];
          end else if (is_mv) begin
            trmt_d = 1'b1;
            resp_d = ACK;
          end else begin
            trmt_d = 1'b1;
            resp_d = NAK;
          end
        end
      end
      StCalWait, StMvWait: begin
        // Done takes priority over a simultaneous expiry.
        if (op_done) begin
          trmt_d = 1'b1;
          resp_d = ACK;
        end else if (expired) begin
          trmt_d = 1'b1;
          resp_d = TMO;
          cnt_d  = cnt_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRespWait: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output, counter and tx_done edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tx_done_q  <= 1'b0;
      clr_q      <= 1'b0;
      strt_cal_q <= 1'b0;
      strt_mv_q  <= 1'b0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      resp_q     <= 8'h00;
      hd_q       <= 8'h00;
      sq_q       <= 4'h0;
    end else begin
      cnt_q      <= cnt_d;
      tx_done_q  <= tx_done_i;
      clr_q      <= clr_d;
      strt_cal_q <= strt_cal_d;
      strt_mv_q  <= strt_mv_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      resp_q     <= resp_d;
      hd_q       <= hd_d;
      sq_q       <= sq_d;
    end
  end

  assign clr_cmd_rdy_o = clr_q;
  assign strt_cal_o    = strt_cal_q;
  assign strt_mv_o     = strt_mv_q;
  assign trmt_o        = trmt_q;
  assign busy_o        = busy_q;
  assign resp_o        = resp_q;
  assign mv_heading_o  = hd_q;
  assign mv_squares_o  = sq_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: stimulus pushes expected responses into a queue,
// an independent monitor checks accepts and responses as the DUT emits them.
module tb_cmd_dispatch;

  localparam int unsigned TIMEOUT = 100;
  localparam logic [7:0]  ACK     = 8'hA5;
  localparam logic [7:0]  NAK     = 8'h5A;
  localparam logic [7:0]  TMO     = 8'hEE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_i;
  logic        cmd_rdy_i, clr_cmd_rdy_o, strt_cal_o, cal_done_i, strt_mv_o;
  logic [7:0]  mv_heading_o, resp_o;
  logic [3:0]  mv_squares_o;
  logic        mv_done_i, trmt_o, tx_done_i, busy_o;

  cmd_dispatch #(.TIMEOUT(TIMEOUT), .ACK(ACK), .NAK(NAK), .TMO(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_i        (cmd_i),
    .cmd_rdy_i    (cmd_rdy_i),
    .clr_cmd_rdy_o(clr_cmd_rdy_o),
    .strt_cal_o   (strt_cal_o),
    .cal_done_i   (cal_done_i),
    .strt_mv_o    (strt_mv_o),
    .mv_heading_o (mv_heading_o),
    .mv_squares_o (mv_squares_o),
    .mv_done_i    (mv_done_i),
    .resp_o       (resp_o),
    .trmt_o       (trmt_o),
    .tx_done_i    (tx_done_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  resp;
    bit          cal;
    bit          mv;
    int          lat;   // cycles from accept to trmt
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  bit         acc_open = 1'b0;
  int         acc_cyc  = 0;
  logic [7:0] last_hd   = 8'h00;
  logic [3:0] last_sq   = 4'h0;
  logic [7:0] last_resp = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: response byte and accept-to-trmt latency from the command and
  // the cycle (after start) at which done arrives; d < 0 means never.
  function automatic exp_t model(input logic [15:0] c, input int d);
    exp_t e;
    bit   ok;
    ok     = (d >= 0) && (d <= int'(TIMEOUT));
    e.cmd  = c;
    e.cal  = 1'b0;
    e.mv   = 1'b0;
    e.resp = NAK;
    e.lat  = 0;
    if (c[15:12] == 4'h2) begin
      e.cal  = 1'b1;
      e.resp = ok ? ACK : TMO;
      e.lat  = ok ? d + 1 : int'(TIMEOUT) + 1;
    end else if (c[15:12] == 4'h4) begin
      if (c[3:0] != 4'h0) begin
        e.mv   = 1'b1;
        e.resp = ok ? ACK : TMO;
        e.lat  = ok ? d + 1 : int'(TIMEOUT) + 1;
      end else begin
        e.resp = ACK;
      end
    end
    return e;
  endfunction

  // UART wrapper side: cmd_rdy drops once the clear pulse is seen.
  initial forever begin
    @(negedge clk);
    if (clr_cmd_rdy_o) cmd_rdy_i = 1'b0;
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (clr_cmd_rdy_o) begin
        if (acc_open || exp_q.size() == 0) begin
          check("extra_accept", 32'd1, 32'd0);
        end else begin
          e        = exp_q[0];
          acc_open = 1'b1;
          acc_cyc  = cyc;
          check("accept_busy", busy_o, 1);
          check("accept_strt_cal", strt_cal_o, e.cal);
          check("accept_strt_mv", strt_mv_o, e.mv);
          if (e.mv) begin
            last_hd = e.cmd[11:4];
            last_sq = e.cmd[3:0];
            check("mv_heading", mv_heading_o, last_hd);
            check("mv_squares", mv_squares_o, last_sq);
          end
        end
      end else if (strt_cal_o || strt_mv_o) begin
        check("stray_start", {strt_cal_o, strt_mv_o}, 0);
      end
      if (trmt_o) begin
        if (!acc_open) begin
          check("stray_trmt", 32'd1, 32'd0);
        end else begin
          e         = exp_q.pop_front();
          acc_open  = 1'b0;
          last_resp = e.resp;
          check("resp", resp_o, e.resp);
          check("resp_latency", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  // One command from issue to release of RESP_WAIT. pending: the command was
  // already raised earlier. b2b: raise c2 while this one is still in flight.
  task automatic run_cmd(input logic [15:0] c, input int d, input bit pending, input bit wrong,
                         input bit b2b, input logic [15:0] c2);
    int n;
    int elapsed;
    bit need_done;
    bit is_cal;
    need_done = (c[15:12] == 4'h2) || (c[15:12] == 4'h4 && c[3:0] != 4'h0);
    is_cal    = (c[15:12] == 4'h2);
    if (!pending) begin
      exp_q.push_back(model(c, d));
      @(negedge clk);
      cmd_i     = c;
      cmd_rdy_i = 1'b1;
    end
    n = 0;
    while (!clr_cmd_rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!clr_cmd_rdy_o) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    elapsed = 0;
    if (b2b) begin
      @(negedge clk);
      elapsed   = 1;
      cmd_i     = c2;
      cmd_rdy_i = 1'b1;
      exp_q.push_back(model(c2, -1));
    end
    if (need_done && wrong && (d < 0 || d - elapsed >= 2)) begin
      @(negedge clk);
      if (is_cal) mv_done_i = 1'b1; else cal_done_i = 1'b1;
      @(negedge clk);
      mv_done_i  = 1'b0;
      cal_done_i = 1'b0;
      elapsed += 2;
    end
    if (need_done && d >= 0) begin
      repeat (d - elapsed) @(negedge clk);
      if (is_cal) cal_done_i = 1'b1; else mv_done_i = 1'b1;
      @(negedge clk);
      cal_done_i = 1'b0;
      mv_done_i  = 1'b0;
    end
    n = 0;
    while (!trmt_o && n < int'(TIMEOUT) + 20) begin
      @(negedge clk);
      n++;
    end
    if (!trmt_o) begin
      check("trmt_timeout", 32'd0, 32'd1);
      return;
    end
    if (tx_done_i) begin
      repeat (3) @(negedge clk);
      check("stale_tx_hold", busy_o, 1);
      tx_done_i = 1'b0;
      @(negedge clk);
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    tx_done_i = 1'b1;
    check("busy_before_edge", busy_o, 1);
    @(negedge clk);
    check("busy_after_edge", busy_o, 0);
    check("resp_hold", resp_o, last_resp);
    check("heading_hold", mv_heading_o, last_hd);
    check("squares_hold", mv_squares_o, last_sq);
    tx_done_i = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int r;
    logic [3:0]  op;
    logic [15:0] c;
    rst_n      = 1'b0;
    cmd_i      = 16'h0000;
    cmd_rdy_i  = 1'b0;
    cal_done_i = 1'b0;
    mv_done_i  = 1'b0;
    tx_done_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_resp", resp_o, 8'h00);
    check("rst_trmt", trmt_o, 0);
    check("rst_clr", clr_cmd_rdy_o, 0);
    check("rst_heading", mv_heading_o, 8'h00);
    check("rst_squares", mv_squares_o, 4'h0);
    rst_n = 1'b1;

    run_cmd(16'h2000, 20, 0, 0, 0, 16'h0);
    run_cmd(16'h4AB3, 15, 0, 1, 0, 16'h0);
    run_cmd(16'h4120, 0, 0, 0, 0, 16'h0);
    run_cmd(16'hF00F, 0, 0, 0, 0, 16'h0);
    run_cmd(16'h2000, -1, 0, 1, 0, 16'h0);
    run_cmd(16'h2000, int'(TIMEOUT), 0, 0, 0, 16'h0);
    run_cmd(16'h4123, 10, 0, 0, 1, 16'hF00F);
    run_cmd(16'hF00F, -1, 1, 0, 0, 16'h0);
    tx_done_i = 1'b1;
    run_cmd(16'h4A11, 5, 0, 0, 0, 16'h0);

    // Reset in the middle of a move, with another command pending.
    tx_done_i = 1'b0;
    exp_q.push_back(model(16'h4C57, -1));
    @(negedge clk);
    cmd_i     = 16'h4C57;
    cmd_rdy_i = 1'b1;
    n = 0;
    while (!clr_cmd_rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_move_accept", clr_cmd_rdy_o, 1);
    repeat (10) @(negedge clk);
    cmd_i     = 16'h4120;
    cmd_rdy_i = 1'b1;
    exp_q.push_back(model(16'h4120, -1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_trmt", trmt_o, 0);
    check("arst_strt", {strt_cal_o, strt_mv_o, clr_cmd_rdy_o}, 0);
    check("arst_resp", resp_o, 8'h00);
    check("arst_heading", mv_heading_o, 8'h00);
    check("arst_squares", mv_squares_o, 4'h0);
    void'(exp_q.pop_front());
    acc_open  = 1'b0;
    last_hd   = 8'h00;
    last_sq   = 4'h0;
    last_resp = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_hold_trmt", trmt_o, 0);
    rst_n = 1'b1;
    run_cmd(16'h4120, -1, 1, 0, 0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 3);
      op = (r == 0) ? 4'h2 : (r == 3) ? 4'($urandom_range(0, 15)) : 4'h4;
      c  = {op, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 4) == 0) c[3:0] = 4'h0;
      r = $urandom_range(0, 9);
      d = (r == 0) ? -1 : (r == 1) ? int'(TIMEOUT) : $urandom_range(0, 30);
      run_cmd(c, d, 0, 1'($urandom_range(0, 1)), 0, 16'h0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
- Sits directly downstream of UART_wrapper and consumes its 16-bit command stream (cmd/cmd_rdy).
- Acknowledges each command via clr_cmd_rdy and decodes the opcode.
- Launches calibrate or move operations on the datapath and waits for completion or timeout.
- Returns a one-byte status response through UART_wrapper's trmt/resp/tx_done interface.

Parameters:
- TIMEOUT, 1000000: max cycles to wait for cal_done/mv_done before reporting a timeout.
- ACK, 8'hA5: response byte on success.
- NAK, 8'h5A: response byte for an illegal opcode.
- TMO, 8'hEE: response byte on timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command word from UART_wrapper
- cmd_rdy  in  1  command valid; level, held until cleared
- clr_cmd_rdy  out  1  one-cycle pulse clearing cmd_rdy in UART_wrapper
- strt_cal  out  1  one-cycle calibrate start
- cal_done  in  1  calibrate complete (pulse or level)
- strt_mv  out  1  one-cycle move start
- mv_heading  out  8  move heading, cmd[11:4]
- mv_squares  out  4  move length, cmd[3:0]
- mv_done  in  1  move complete (pulse or level)
- resp  out  8  response byte to UART_wrapper
- trmt  out  1  one-cycle transmit request
- tx_done  in  1  UART transmit done; may stay high between transmissions
- busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- All outputs are registered. Reset values:
  - clr_cmd_rdy, strt_cal, strt_mv, trmt, busy = 0
  - resp = 8'h00, mv_heading = 0, mv_squares = 0
  - state = IDLE, timeout counter = 0, tx_done edge register = 0
- Opcode is cmd[15:12]:
  - 4'h2 = calibrate
  - 4'h4 = move
  - all other values are illegal
- States: IDLE, CAL_WAIT, MV_WAIT, RESP_WAIT.
- IDLE, cmd_rdy sampled high in cycle N. Cycle N+1 sees clr_cmd_rdy = 1 for exactly one cycle and busy = 1, plus:
  - calibrate: strt_cal = 1; go to CAL_WAIT.
  - move with cmd[3:0] != 0: mv_heading/mv_squares latched, strt_mv = 1; go to MV_WAIT.
  - move with cmd[3:0] == 0: no strt_mv; trmt = 1, resp = ACK; go to RESP_WAIT.
  - illegal opcode: trmt = 1, resp = NAK; go to RESP_WAIT.
- CAL_WAIT / MV_WAIT:
  - Timeout counter clears on entry and increments each cycle.
  - Matching done high in cycle M: trmt = 1, resp = ACK at M+1; go to RESP_WAIT.
  - Counter reaching TIMEOUT with no done: trmt = 1, resp = TMO next cycle; go to RESP_WAIT.
  - If done and timeout expiry happen in the same cycle, done wins and ACK is sent.
  - The non-matching done input is ignored (e.g. mv_done while in CAL_WAIT).
- RESP_WAIT:
  - Leaves only on a rising edge of tx_done, detected against a registered copy.
  - A stale high level of tx_done from a prior transmission does not release the state.
  - On the edge, returns to IDLE next cycle; busy = 0.
- resp holds its value until the next trmt.
- mv_heading/mv_squares hold their values until the next accepted move.
- cmd_rdy while busy is ignored; the command stays pending in UART_wrapper and is taken on return to IDLE. It is never dropped.
- clr_cmd_rdy is issued once per accepted command.
- cmd_rdy still high in the cycle after clr_cmd_rdy (clear latency) must not cause a second accept. The FSM is no longer in IDLE by then, so this holds.
- Reset mid-operation: everything returns to reset values immediately with no partial trmt. A command still pending in UART_wrapper is processed after reset release.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

Test Plan:
- Bench runs with TIMEOUT = 100.
- Calibrate: cmd = 16'h2000, cmd_rdy pulse; cal_done 20 cycles after strt_cal -> one clr_cmd_rdy and one strt_cal pulse, then trmt with resp = 8'hA5 on the cycle after cal_done. On tx_done rising edge, busy falls next cycle.
- Move: cmd = 16'h4AB3 -> strt_mv pulse, mv_heading = 8'hAB, mv_squares = 3. mv_done returns resp = 8'hA5.
- Zero-square move and illegal opcode:
  - cmd = 16'h4120 -> no strt_mv, resp = 8'hA5 in the cycle after accept.
  - cmd = 16'hF00F -> resp = 8'h5A, no strt_cal or strt_mv.
- Timeout and collision:
  - cal_done never asserted -> resp = 8'hEE after 100 cycles.
  - Repeat with cal_done arriving on the expiry cycle -> resp = 8'hA5.
- Back-to-back and stale tx_done:
  - Second cmd_rdy while in MV_WAIT -> not accepted until IDLE, then exactly one extra clr_cmd_rdy.
  - tx_done held high from before trmt -> FSM stays in RESP_WAIT until a fresh rising edge.
- Reset: assert rst_n low mid-MV_WAIT -> all outputs 0 asynchronously, no trmt. After release, pending cmd_rdy is re-accepted.
